// File: rtl/fft8_ctrl.sv
// Sequencing controller for an 8-point radix-2 DIT FFT: bit-reversed load,
// 3x4 butterfly issue with delayed write-back, and natural-order unload.
module fft8_ctrl #(
  parameter int BF_LATENCY = 2
) (
  input  logic       clk_i,
  input  logic       reset,
  input  logic       s_tvalid,
  input  logic       s_tlast,
  output logic       s_tready,
  output logic       wr_en,
  output logic [2:0] wr_addr,
  output logic       bf_start,
  output logic [2:0] bf_addr_a,
  output logic [2:0] bf_addr_b,
  output logic [1:0] tw_idx,
  output logic [1:0] stage,
  output logic       bf_wr_en,
  output logic [2:0] bf_wr_addr_a,
  output logic [2:0] bf_wr_addr_b,
  output logic       m_tvalid,
  output logic       m_tlast,
  input  logic       m_tready,
  output logic [2:0] rd_addr,
  output logic       busy,
  output logic       frame_err
);

  typedef enum logic [1:0] {LOAD, COMPUTE, OUTPUT} state_t;

  localparam int         PHASE_LEN  = 4 + BF_LATENCY;
  localparam logic [3:0] PHASE_LAST = 4'(PHASE_LEN - 1);
  localparam int         WB_W       = 3 * BF_LATENCY;

  state_t            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [2:0]        ocnt_q, ocnt_d;
  logic [1:0]        stage_q, stage_d;
  logic [3:0]        pcnt_q, pcnt_d;
  logic              s_tready_q, s_tready_d;
  logic              frame_err_q, frame_err_d;
  logic              bf_start_q, bf_start_d;
  logic [2:0]        bf_addr_a_q, bf_addr_a_d;
  logic [2:0]        bf_addr_b_q, bf_addr_b_d;
  logic [1:0]        tw_idx_q, tw_idx_d;
  logic [BF_LATENCY-1:0] wb_vld_q, wb_vld_d;
  logic [WB_W-1:0]   wb_a_q, wb_a_d;
  logic [WB_W-1:0]   wb_b_q, wb_b_d;
  logic [BF_LATENCY:0] wb_vld_cat;
  logic [WB_W+2:0]   wb_a_cat;
  logic [WB_W+2:0]   wb_b_cat;
  logic              hs_in;
  logic              hs_out;

  function automatic logic [2:0] bitrev3(input logic [2:0] v);
    return {v[0], v[1], v[2]};
  endfunction

  // Operand A: k with a zero inserted at bit position s.
  function automatic logic [2:0] op_addr_a(input logic [1:0] s, input logic [1:0] k);
    case (s)
      2'd0:    return {k, 1'b0};
      2'd1:    return {k[1], 1'b0, k[0]};
      default: return {1'b0, k};
    endcase
  endfunction

  function automatic logic [2:0] op_span(input logic [1:0] s);
    case (s)
      2'd0:    return 3'd1;
      2'd1:    return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic [1:0] twiddle(input logic [1:0] s, input logic [1:0] k);
    case (s)
      2'd0:    return 2'd0;
      2'd1:    return {k[0], 1'b0};
      default: return k;
    endcase
  endfunction

  assign hs_in  = s_tvalid & s_tready_q;
  assign hs_out = (state_q == OUTPUT) & m_tready;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ocnt_d      = ocnt_q;
    stage_d     = stage_q;
    pcnt_d      = pcnt_q;
    frame_err_d = 1'b0;

    case (state_q)
      LOAD: begin
        if (hs_in) begin
          if (cnt_q == 3'd7) begin
            cnt_d       = 3'd0;
            pcnt_d      = 4'd0;
            stage_d     = 2'd0;
            state_d     = COMPUTE;
            frame_err_d = ~s_tlast;
          end else if (s_tlast) begin
            cnt_d       = 3'd0;
            frame_err_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      COMPUTE: begin
        if (pcnt_q == PHASE_LAST) begin
          pcnt_d = 4'd0;
          if (stage_q == 2'd2) begin
            stage_d = 2'd0;
            ocnt_d  = 3'd0;
            state_d = OUTPUT;
          end else begin
            stage_d = stage_q + 2'd1;
          end
        end else begin
          pcnt_d = pcnt_q + 4'd1;
        end
      end
      OUTPUT: begin
        if (hs_out) begin
          if (ocnt_q == 3'd7) begin
            ocnt_d  = 3'd0;
            state_d = LOAD;
          end else begin
            ocnt_d = ocnt_q + 3'd1;
          end
        end
      end
      default: state_d = LOAD;
    endcase

    // Issue outputs are registered, so they are derived from the next state.
    s_tready_d  = (state_d == LOAD);
    bf_start_d  = (state_d == COMPUTE) && (pcnt_d < 4'd4);
    bf_addr_a_d = 3'd0;
    bf_addr_b_d = 3'd0;
    tw_idx_d    = 2'd0;
    if (bf_start_d) begin
      bf_addr_a_d = op_addr_a(stage_d, pcnt_d[1:0]);
      bf_addr_b_d = op_addr_a(stage_d, pcnt_d[1:0]) + op_span(stage_d);
      tw_idx_d    = twiddle(stage_d, pcnt_d[1:0]);
    end

    wb_vld_cat = {wb_vld_q, bf_start_q};
    wb_a_cat   = {wb_a_q, bf_addr_a_q};
    wb_b_cat   = {wb_b_q, bf_addr_b_q};
    wb_vld_d   = wb_vld_cat[BF_LATENCY-1:0];
    wb_a_d     = wb_a_cat[WB_W-1:0];
    wb_b_d     = wb_b_cat[WB_W-1:0];
  end

  always_ff @(posedge clk_i or negedge reset) begin
    if (!reset) begin
      state_q     <= LOAD;
      cnt_q       <= 3'd0;
      ocnt_q      <= 3'd0;
      stage_q     <= 2'd0;
      pcnt_q      <= 4'd0;
      s_tready_q  <= 1'b0;
      frame_err_q <= 1'b0;
      bf_start_q  <= 1'b0;
      bf_addr_a_q <= 3'd0;
      bf_addr_b_q <= 3'd0;
      tw_idx_q    <= 2'd0;
      wb_vld_q    <= '0;
      wb_a_q      <= '0;
      wb_b_q      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ocnt_q      <= ocnt_d;
      stage_q     <= stage_d;
      pcnt_q      <= pcnt_d;
      s_tready_q  <= s_tready_d;
      frame_err_q <= frame_err_d;
      bf_start_q  <= bf_start_d;
      bf_addr_a_q <= bf_addr_a_d;
      bf_addr_b_q <= bf_addr_b_d;
      tw_idx_q    <= tw_idx_d;
      wb_vld_q    <= wb_vld_d;
      wb_a_q      <= wb_a_d;
      wb_b_q      <= wb_b_d;
    end
  end

  assign s_tready     = s_tready_q;
  assign wr_en        = hs_in;
  assign wr_addr      = bitrev3(cnt_q);
  assign bf_start     = bf_start_q;
  assign bf_addr_a    = bf_addr_a_q;
  assign bf_addr_b    = bf_addr_b_q;
  assign tw_idx       = tw_idx_q;
  assign stage        = stage_q;
  assign bf_wr_en     = wb_vld_q[BF_LATENCY-1];
  assign bf_wr_addr_a = wb_a_q[WB_W-1 -: 3];
  assign bf_wr_addr_b = wb_b_q[WB_W-1 -: 3];
  assign m_tvalid     = (state_q == OUTPUT);
  assign m_tlast      = (state_q == OUTPUT) && (ocnt_q == 3'd7);
  assign rd_addr      = ocnt_q;
  assign busy         = (state_q != LOAD);
  assign frame_err    = frame_err_q;

endmodule

// File: tb/tb_fft8_ctrl.sv
// Directed bench for fft8_ctrl: one instance at BF_LATENCY=2, one at 4.
module tb_fft8_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic s_tvalid, s_tlast, m_tready;
  logic s_tready, wr_en, bf_start, bf_wr_en, m_tvalid, m_tlast, busy, frame_err;
  logic [2:0] wr_addr, bf_addr_a, bf_addr_b, bf_wr_addr_a, bf_wr_addr_b, rd_addr;
  logic [1:0] tw_idx, stage;

  logic s4_tvalid, s4_tlast, m4_tready;
  logic d4_s_tready, d4_wr_en, d4_bf_start, d4_bf_wr_en, d4_m_tvalid, d4_m_tlast, d4_busy, d4_frame_err;
  logic [2:0] d4_wr_addr, d4_bf_addr_a, d4_bf_addr_b, d4_bf_wr_addr_a, d4_bf_wr_addr_b, d4_rd_addr;
  logic [1:0] d4_tw_idx, d4_stage;

  fft8_ctrl #(.BF_LATENCY(2)) dut2 (
    .clk_i(clk), .reset(rst_n), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
    .wr_en(wr_en), .wr_addr(wr_addr), .bf_start(bf_start), .bf_addr_a(bf_addr_a),
    .bf_addr_b(bf_addr_b), .tw_idx(tw_idx), .stage(stage), .bf_wr_en(bf_wr_en),
    .bf_wr_addr_a(bf_wr_addr_a), .bf_wr_addr_b(bf_wr_addr_b), .m_tvalid(m_tvalid),
    .m_tlast(m_tlast), .m_tready(m_tready), .rd_addr(rd_addr), .busy(busy), .frame_err(frame_err)
  );

  fft8_ctrl #(.BF_LATENCY(4)) dut4 (
    .clk_i(clk), .reset(rst_n), .s_tvalid(s4_tvalid), .s_tlast(s4_tlast), .s_tready(d4_s_tready),
    .wr_en(d4_wr_en), .wr_addr(d4_wr_addr), .bf_start(d4_bf_start), .bf_addr_a(d4_bf_addr_a),
    .bf_addr_b(d4_bf_addr_b), .tw_idx(d4_tw_idx), .stage(d4_stage), .bf_wr_en(d4_bf_wr_en),
    .bf_wr_addr_a(d4_bf_wr_addr_a), .bf_wr_addr_b(d4_bf_wr_addr_b), .m_tvalid(d4_m_tvalid),
    .m_tlast(d4_m_tlast), .m_tready(m4_tready), .rd_addr(d4_rd_addr), .busy(d4_busy),
    .frame_err(d4_frame_err)
  );

  logic [29:0] all2, all4;
  assign all2 = {s_tready, wr_en, wr_addr, bf_start, bf_addr_a, bf_addr_b, tw_idx, stage, bf_wr_en,
                 bf_wr_addr_a, bf_wr_addr_b, m_tvalid, m_tlast, rd_addr, busy, frame_err};
  assign all4 = {d4_s_tready, d4_wr_en, d4_wr_addr, d4_bf_start, d4_bf_addr_a, d4_bf_addr_b,
                 d4_tw_idx, d4_stage, d4_bf_wr_en, d4_bf_wr_addr_a, d4_bf_wr_addr_b, d4_m_tvalid,
                 d4_m_tlast, d4_rd_addr, d4_busy, d4_frame_err};

  int total = 0;
  int bad   = 0;

  logic [2:0] br_tab [8]  = '{3'd0, 3'd4, 3'd2, 3'd6, 3'd1, 3'd5, 3'd3, 3'd7};
  logic [2:0] exp_a  [12] = '{3'd0, 3'd2, 3'd4, 3'd6, 3'd0, 3'd1, 3'd4, 3'd5, 3'd0, 3'd1, 3'd2, 3'd3};
  logic [2:0] exp_b  [12] = '{3'd1, 3'd3, 3'd5, 3'd7, 3'd2, 3'd3, 3'd6, 3'd7, 3'd4, 3'd5, 3'd6, 3'd7};
  logic [1:0] exp_tw [12] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd2, 2'd0, 2'd2, 2'd0, 2'd1, 2'd2, 2'd3};

  task automatic test_reset();
    rst_n = 1'b0;
    s_tvalid = 1'b0; s_tlast = 1'b0; m_tready = 1'b0;
    s4_tvalid = 1'b0; s4_tlast = 1'b0; m4_tready = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    total++; if (all2 !== 30'd0) begin bad++; $display("FAIL reset_outs2 got=%h want=0", all2); end
    total++; if (all4 !== 30'd0) begin bad++; $display("FAIL reset_outs4 got=%h want=0", all4); end
    rst_n = 1'b1;
    #1;
    total++; if (s_tready !== 1'b0) begin bad++; $display("FAIL tready_before_edge got=%b want=0", s_tready); end
    @(posedge clk); #1;
    #1;
    total++; if (s_tready !== 1'b1) begin bad++; $display("FAIL tready_after_release got=%b want=1", s_tready); end
    @(posedge clk); #1;
  endtask

  // Eight beats, tlast on the last; ends at the first COMPUTE cycle.
  task automatic test_load();
    for (int i = 0; i < 8; i++) begin
      s_tvalid = 1'b1; s_tlast = (i == 7);
      #1;
      total++; if (wr_en !== 1'b1) begin bad++; $display("FAIL load_wr_en beat=%0d got=%b want=1", i, wr_en); end
      total++; if (wr_addr !== br_tab[i]) begin bad++; $display("FAIL load_wr_addr beat=%0d got=%0d want=%0d", i, wr_addr, br_tab[i]); end
      total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL load_frame_err beat=%0d got=%b want=0", i, frame_err); end
      @(posedge clk); #1;
    end
    s_tvalid = 1'b0; s_tlast = 1'b0;
  endtask

  task automatic test_compute();
    for (int c = 0; c < 18; c++) begin
      int st, ph, idx, w, widx;
      logic exp_s, exp_w;
      st = c / 6; ph = c % 6; idx = st * 4 + ph;
      exp_s = (ph < 4);
      w = c - 2; exp_w = (w >= 0) && ((w % 6) < 4); widx = (w / 6) * 4 + (w % 6);
      #1;
      total++; if ({s_tready, busy, m_tvalid, frame_err, wr_en} !== 5'b01000) begin bad++; $display("FAIL cmp_ctrl c=%0d got=%b want=01000", c, {s_tready, busy, m_tvalid, frame_err, wr_en}); end
      total++; if (bf_start !== exp_s) begin bad++; $display("FAIL cmp_bf_start c=%0d got=%b want=%b", c, bf_start, exp_s); end
      total++; if (stage !== st[1:0]) begin bad++; $display("FAIL cmp_stage c=%0d got=%0d want=%0d", c, stage, st); end
      if (exp_s) begin
        total++; if ({bf_addr_a, bf_addr_b, tw_idx} !== {exp_a[idx], exp_b[idx], exp_tw[idx]}) begin
          bad++; $display("FAIL cmp_issue c=%0d got=(%0d,%0d,%0d) want=(%0d,%0d,%0d)", c, bf_addr_a, bf_addr_b, tw_idx, exp_a[idx], exp_b[idx], exp_tw[idx]); end
      end
      total++; if (bf_wr_en !== exp_w) begin bad++; $display("FAIL cmp_wr_en c=%0d got=%b want=%b", c, bf_wr_en, exp_w); end
      if (exp_w) begin
        total++; if ({bf_wr_addr_a, bf_wr_addr_b} !== {exp_a[widx], exp_b[widx]}) begin
          bad++; $display("FAIL cmp_wb_addr c=%0d got=(%0d,%0d) want=(%0d,%0d)", c, bf_wr_addr_a, bf_wr_addr_b, exp_a[widx], exp_b[widx]); end
      end
      @(posedge clk); #1;
    end
    #1;
    total++; if ({m_tvalid, bf_start, bf_wr_en, stage} !== 5'b10000) begin bad++; $display("FAIL cmp_exit got=%b want=10000", {m_tvalid, bf_start, bf_wr_en, stage}); end
  endtask

  task automatic test_output();
    logic pat [11] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [2:0] ocnt = 3'd0;
    for (int i = 0; i < 11; i++) begin
      m_tready = pat[i];
      #1;
      total++; if (m_tvalid !== 1'b1) begin bad++; $display("FAIL out_tvalid i=%0d got=%b want=1", i, m_tvalid); end
      total++; if (rd_addr !== ocnt) begin bad++; $display("FAIL out_rd_addr i=%0d got=%0d want=%0d", i, rd_addr, ocnt); end
      total++; if (m_tlast !== (ocnt == 3'd7)) begin bad++; $display("FAIL out_tlast i=%0d got=%b want=%b", i, m_tlast, (ocnt == 3'd7)); end
      if (pat[i]) ocnt = ocnt + 3'd1;
      @(posedge clk); #1;
    end
    m_tready = 1'b0;
    #1;
    total++; if ({m_tvalid, s_tready, busy} !== 3'b010) begin bad++; $display("FAIL out_done got=%b want=010", {m_tvalid, s_tready, busy}); end
    @(posedge clk); #1;
  endtask

  task automatic test_frame_err();
    for (int i = 0; i < 4; i++) begin
      s_tvalid = 1'b1; s_tlast = (i == 3);
      #1;
      total++; if (wr_addr !== br_tab[i]) begin bad++; $display("FAIL short_wr_addr beat=%0d got=%0d want=%0d", i, wr_addr, br_tab[i]); end
      @(posedge clk); #1;
    end
    s_tvalid = 1'b0; s_tlast = 1'b0;
    #1;
    total++; if ({frame_err, busy, s_tready} !== 3'b101) begin bad++; $display("FAIL short_err got=%b want=101", {frame_err, busy, s_tready}); end
    @(posedge clk); #1;
    #1;
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL short_err_pulse got=%b want=0", frame_err); end
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) begin
      s_tvalid = 1'b1; s_tlast = 1'b0;
      #1;
      total++; if (wr_addr !== br_tab[i]) begin bad++; $display("FAIL notlast_wr_addr beat=%0d got=%0d want=%0d", i, wr_addr, br_tab[i]); end
      @(posedge clk); #1;
    end
    s_tvalid = 1'b0;
    #1;
    total++; if ({frame_err, busy, bf_start} !== 3'b111) begin bad++; $display("FAIL notlast_err got=%b want=111", {frame_err, busy, bf_start}); end
    @(posedge clk); #1;
    #1;
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL notlast_err_pulse got=%b want=0", frame_err); end
    repeat (17) @(posedge clk);
    #1;
    m_tready = 1'b1;
    #1;
    total++; if ({m_tvalid, rd_addr} !== 4'b1000) begin bad++; $display("FAIL notlast_output got=%b want=1000", {m_tvalid, rd_addr}); end
    repeat (8) @(posedge clk);
    #1;
    m_tready = 1'b0;
    #1;
    total++; if ({busy, s_tready} !== 2'b01) begin bad++; $display("FAIL notlast_done got=%b want=01", {busy, s_tready}); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 8; i++) begin
      s_tvalid = 1'b1; s_tlast = (i == 7);
      @(posedge clk); #1;
    end
    s_tvalid = 1'b0; s_tlast = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    #1;
    total++; if ({bf_start, stage, bf_addr_a, bf_addr_b} !== {1'b1, 2'd1, 3'd1, 3'd3}) begin
      bad++; $display("FAIL mid_issue got=%b want=%b", {bf_start, stage, bf_addr_a, bf_addr_b}, {1'b1, 2'd1, 3'd1, 3'd3}); end
    rst_n = 1'b0;
    #1;
    total++; if (all2 !== 30'd0) begin bad++; $display("FAIL mid_async_clear got=%h want=0", all2); end
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk); #1;
    #1;
    total++; if (s_tready !== 1'b1) begin bad++; $display("FAIL mid_tready got=%b want=1", s_tready); end
    for (int i = 0; i < 10; i++) begin
      total++; if ({bf_wr_en, bf_start, busy} !== 3'b000) begin bad++; $display("FAIL mid_quiet i=%0d got=%b want=000", i, {bf_wr_en, bf_start, busy}); end
      @(posedge clk); #2;
    end
  endtask

  task automatic test_latency4();
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) begin
      s4_tvalid = 1'b1; s4_tlast = (i == 7);
      #1;
      total++; if (d4_wr_addr !== br_tab[i]) begin bad++; $display("FAIL l4_wr_addr beat=%0d got=%0d want=%0d", i, d4_wr_addr, br_tab[i]); end
      @(posedge clk); #1;
    end
    s4_tvalid = 1'b0; s4_tlast = 1'b0;
    for (int c = 0; c < 24; c++) begin
      int st, ph, idx, w, widx;
      logic exp_s, exp_w;
      st = c / 8; ph = c % 8; idx = st * 4 + ph;
      exp_s = (ph < 4);
      w = c - 4; exp_w = (w >= 0) && ((w % 8) < 4); widx = (w / 8) * 4 + (w % 8);
      #1;
      total++; if ({d4_busy, d4_m_tvalid, d4_s_tready} !== 3'b100) begin bad++; $display("FAIL l4_ctrl c=%0d got=%b want=100", c, {d4_busy, d4_m_tvalid, d4_s_tready}); end
      total++; if (d4_bf_start !== exp_s) begin bad++; $display("FAIL l4_bf_start c=%0d got=%b want=%b", c, d4_bf_start, exp_s); end
      total++; if (d4_stage !== st[1:0]) begin bad++; $display("FAIL l4_stage c=%0d got=%0d want=%0d", c, d4_stage, st); end
      if (exp_s) begin
        total++; if ({d4_bf_addr_a, d4_bf_addr_b, d4_tw_idx} !== {exp_a[idx], exp_b[idx], exp_tw[idx]}) begin
          bad++; $display("FAIL l4_issue c=%0d got=(%0d,%0d,%0d) want=(%0d,%0d,%0d)", c, d4_bf_addr_a, d4_bf_addr_b, d4_tw_idx, exp_a[idx], exp_b[idx], exp_tw[idx]); end
      end
      total++; if (d4_bf_wr_en !== exp_w) begin bad++; $display("FAIL l4_wr_en c=%0d got=%b want=%b", c, d4_bf_wr_en, exp_w); end
      if (exp_w) begin
        total++; if ({d4_bf_wr_addr_a, d4_bf_wr_addr_b} !== {exp_a[widx], exp_b[widx]}) begin
          bad++; $display("FAIL l4_wb_addr c=%0d got=(%0d,%0d) want=(%0d,%0d)", c, d4_bf_wr_addr_a, d4_bf_wr_addr_b, exp_a[widx], exp_b[widx]); end
      end
      @(posedge clk); #1;
    end
    m4_tready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      #1;
      total++; if ({d4_m_tvalid, d4_rd_addr, d4_m_tlast} !== {1'b1, 3'(i), (i == 7)}) begin
        bad++; $display("FAIL l4_out i=%0d got=%b want=%b", i, {d4_m_tvalid, d4_rd_addr, d4_m_tlast}, {1'b1, 3'(i), (i == 7)}); end
      @(posedge clk); #1;
    end
    m4_tready = 1'b0;
    #1;
    total++; if ({d4_busy, d4_s_tready} !== 2'b01) begin bad++; $display("FAIL l4_done got=%b want=01", {d4_busy, d4_s_tready}); end
  endtask

  initial begin
    test_reset();
    test_load();
    test_compute();
    test_output();
    test_frame_err();
    test_reset_mid();
    test_latency4();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fft8_ctrl.md
Name: fft8_ctrl

Overview:
Sequencing controller for the 8-point radix-2 DIT FFT datapath in FFT_top.
- Accepts an AXI-stream frame of 8 complex samples and writes them into the sample buffer in bit-reversed order.
- Issues the 12 butterfly operations (3 stages x 4) with operand addresses and twiddle indices, and schedules write-back.
- Streams the natural-order result out over an AXI-stream master handshake.
- Contains no arithmetic datapath; it only drives buffer and butterfly control.

Parameters:
BF_LATENCY, 2, butterfly pipeline depth in cycles from bf_start to result valid; legal range 1..7.

Ports:
- clk_i  in  1  clock, rising edge.
- reset  in  1  asynchronous active-low reset.
- s_tvalid  in  1  input sample valid.
- s_tlast  in  1  input frame end marker.
- s_tready  out  1  controller accepts an input sample.
- wr_en  out  1  load write strobe to the sample buffer (= s_tvalid & s_tready).
- wr_addr  out  3  bit-reversed load address.
- bf_start  out  1  butterfly issue strobe.
- bf_addr_a  out  3  operand A buffer address.
- bf_addr_b  out  3  operand B buffer address.
- tw_idx  out  2  twiddle index k of W8^k.
- stage  out  2  current stage, 0..2.
- bf_wr_en  out  1  result write-back strobe.
- bf_wr_addr_a  out  3  write-back address for A result.
- bf_wr_addr_b  out  3  write-back address for B result.
- m_tvalid  out  1  output sample valid.
- m_tlast  out  1  last output sample.
- m_tready  in  1  downstream accepts.
- rd_addr  out  3  output read address, natural order.
- busy  out  1  high in COMPUTE or OUTPUT.
- frame_err  out  1  one-cycle tlast misalignment pulse.

Behaviour:
- **Reset (reset=0):** asynchronous. State=LOAD; all counters 0; BF_LATENCY delay line cleared. Every output is 0, including s_tready.
- **Reset release:** s_tready=1 from the first clock edge after reset returns high.
- **Reset mid-operation:** any state returns to LOAD. No pending bf_wr_en fires after release; the partial frame is discarded.
- **FSM states:** LOAD, COMPUTE, OUTPUT.
- **LOAD:**
  - s_tready=1.
  - On each handshake, wr_en=1 (combinational) and wr_addr=bitrev(cnt), then cnt++. Sequence: 0,4,2,6,1,5,3,7.
  - s_tlast with cnt<7: frame_err pulses the next cycle, cnt resets to 0, stay in LOAD. That sample is still written but ignored.
  - Beat cnt=7: go to COMPUTE; s_tready=0 from the next cycle. If s_tlast=0 on this beat, frame_err pulses and the frame is still processed.
- **COMPUTE:** for each stage s=0,1,2:
  - 4 consecutive issue cycles k=0..3, with bf_start=1 (registered outputs).
  - span=2^s; a=((k>>s)<<(s+1)) + (k & (span-1)); b=a+span; tw_idx=(k & (span-1))<<(2-s).
  - Stage 0: (0,1,0) (2,3,0) (4,5,0) (6,7,0).
  - Stage 1: (0,2,0) (1,3,2) (4,6,0) (5,7,2).
  - Stage 2: (0,4,0) (1,5,1) (2,6,2) (3,7,3).
  - After the 4th issue: BF_LATENCY gap cycles with bf_start=0, then the next stage begins. Stage s+1 never reads before stage s write-back completes.
  - Total: 3*(4+BF_LATENCY) cycles, then OUTPUT.
- **Write-back:** bf_wr_en, bf_wr_addr_a and bf_wr_addr_b equal bf_start, bf_addr_a and bf_addr_b delayed exactly BF_LATENCY cycles (shift register). The last write-back coincides with the final gap cycle.
- **OUTPUT:**
  - m_tvalid=1; rd_addr=ocnt; m_tlast=(ocnt==7).
  - ocnt advances only on m_tvalid & m_tready. With m_tready=0, rd_addr and m_tlast are held stable.
  - After the beat-7 handshake: m_tvalid=0, state=LOAD, s_tready=1 next cycle.
- **Signal exclusivity:**
  - bf_start and bf_wr_en are 0 outside COMPUTE.
  - wr_en is 0 outside LOAD.
  - stage holds its value through gap cycles and reads 0 outside COMPUTE.
- **Overlap:** no input is accepted during COMPUTE or OUTPUT; frames do not overlap.

Test Plan:
1. Reset, then 8 back-to-back beats with s_tlast on beat 8 -> wr_addr 0,4,2,6,1,5,3,7; s_tready=0 the cycle after beat 8; frame_err never set.
2. Continue scenario 1 with BF_LATENCY=2 -> 12 bf_start pulses with addr/tw exactly per the stage table; 2 idle cycles between stages; bf_wr_en/addresses identical to bf_start/addresses 2 cycles later; COMPUTE lasts 18 cycles.
3. OUTPUT with m_tready pattern 1,0,0,1,1,0,1,1,1,1,1 -> rd_addr 0..7 each held during stalls; m_tlast only with rd_addr=7; s_tready=1 the cycle after the last handshake.
4. s_tlast on beat 4 (cnt=3) -> frame_err single pulse, no COMPUTE entered; next frame's first write at wr_addr 0. Beat 8 without tlast -> frame_err pulse and full compute still runs.
5. Reset driven low on the 2nd issue cycle of stage 1 -> all outputs 0 immediately (asynchronous); after release no bf_wr_en appears and s_tready=1 after one edge.
6. BF_LATENCY=4 -> 4-cycle gaps between stages; bf_wr_en lags bf_start by 4; COMPUTE lasts 24 cycles.
